mem_port_arbiter: RTL and testbench

//  Shares the single external 1024x16 program/data memory port between two requesters.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared 1024x16 program/data memory port.
// Core (r0) has priority; a hold counter forces the aux master (r1) through after MAX_HOLD waits.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflict_cnt,
  output logic [1:0]    state_dbg
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, CORE = 2'd1, AUX = 2'd2} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          rd_pend0;
  logic          rd_pend1;
  logic          xfer0;
  logic          xfer1;

  // Handshake: a master holds req/we/addr/wdata stable until gnt; a transfer happens in
  // every cycle where req & gnt are both high. Dropping req before gnt cancels the access.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset) begin
      if (r0_req && (!r1_req || (hold_cnt < HOLD_LIMIT))) r0_gnt = 1'b1;
      else if (r1_req)                                     r1_gnt = 1'b1;
    end
  end

  assign xfer0     = r0_req & r0_gnt;
  assign xfer1     = r1_req & r1_gnt;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      rd_pend0     <= 1'b0;
      rd_pend1     <= 1'b0;
      r0_rvalid    <= 1'b0;
      r1_rvalid    <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      conflict_cnt <= '0;
      hold_cnt     <= '0;
      state        <= IDLE;
    end else begin
      mem_we <= 1'b0;
      if (xfer0) begin
        mem_addr  <= r0_addr;
        mem_wdata <= r0_wdata;
        mem_we    <= r0_we;
      end else if (xfer1) begin
        mem_addr  <= r1_addr;
        mem_wdata <= r1_wdata;
        mem_we    <= r1_we;
      end

      // Read data is captured at the edge that ends the memory cycle, one beat after accept.
      rd_pend0  <= xfer0 & ~r0_we;
      rd_pend1  <= xfer1 & ~r1_we;
      r0_rvalid <= rd_pend0;
      r1_rvalid <= rd_pend1;
      if (rd_pend0) r0_rdata <= mem_rdata;
      if (rd_pend1) r1_rdata <= mem_rdata;

      if (!r1_req || xfer1)                   hold_cnt <= '0;
      else if (xfer0 && hold_cnt < HOLD_LIMIT) hold_cnt <= hold_cnt + 1'b1;

      if (r0_req && r1_req && (conflict_cnt != {CW{1'b1}}))
        conflict_cnt <= conflict_cnt + 1'b1;

      if (xfer0)      state <= CORE;
      else if (xfer1) state <= AUX;
      else            state <= IDLE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, read-data scoreboard,
// grant-pattern checks and a saturating conflict-count model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [9:0]  r0_addr;
  logic [15:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [9:0]  r1_addr;
  logic [15:0] r1_wdata, r1_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] conflict_cnt;
  logic [1:0]  state_dbg;

  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_conf;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_port_arbiter #(.AW(10), .DW(16), .MAX_HOLD(8), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt), .state_dbg(state_dbg)
  );

  // Clock / memory model
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push expected read data on accept, pop on rvalid; model conflict count.
  always @(negedge clk) begin
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_conf = 16'd0;
    end else begin
      chk("conflict_cnt", conflict_cnt, exp_conf);
      chk("gnt_onehot", r0_gnt & r1_gnt, 0);
      if (r0_rvalid) begin
        if (exp_q0.size() == 0) chk("r0_spurious_rvalid", 1, 0);
        else                    chk("r0_rdata", r0_rdata, exp_q0.pop_front());
      end
      if (r1_rvalid) begin
        if (exp_q1.size() == 0) chk("r1_spurious_rvalid", 1, 0);
        else                    chk("r1_rdata", r1_rdata, exp_q1.pop_front());
      end
      if (r0_req && r0_gnt) begin
        if (r0_we) ref_mem[r0_addr] = r0_wdata;
        else       exp_q0.push_back(ref_mem[r0_addr]);
      end else if (r1_req && r1_gnt) begin
        if (r1_we) ref_mem[r1_addr] = r1_wdata;
        else       exp_q1.push_back(ref_mem[r1_addr]);
      end
      if (r0_req && r1_req && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
    end
  end

  // Driver tasks
  task automatic idle_cycle();
    @(posedge clk); #1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    @(negedge clk);
  endtask

  // Both masters request continuously with random accesses; optionally check the 8:1 pattern.
  task automatic run_both(input int n, input bit pat);
    bit g0 = 1'b1;
    bit g1 = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (g0) begin
        r0_we    = 1'($urandom_range(0, 1));
        r0_addr  = 10'($urandom_range(0, 1023));
        r0_wdata = 16'($urandom_range(0, 65535));
      end
      if (g1) begin
        r1_we    = 1'($urandom_range(0, 1));
        r1_addr  = 10'($urandom_range(0, 1023));
        r1_wdata = 16'($urandom_range(0, 65535));
      end
      r0_req = 1'b1;
      r1_req = 1'b1;
      @(negedge clk);
      g0 = r0_gnt;
      g1 = r1_gnt;
      if (pat) begin
        chk("t3_r0_gnt", r0_gnt, (k % 9) != 8);
        chk("t3_r1_gnt", r1_gnt, (k % 9) == 8);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'hA000 + 16'(i);
      ref_mem[i] = 16'hA000 + 16'(i);
    end
    reset = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_state", state_dbg, 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    r0_req = 1'b0;
    @(negedge clk);

    // Core write 0x005 <- 0xBEEF then read it back
    @(posedge clk); #1;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h005; r0_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t2_wr_gnt", r0_gnt, 1);
    @(posedge clk); #1;
    r0_we = 1'b0;
    @(negedge clk);
    chk("t2_rd_gnt", r0_gnt, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 10'h005);
    chk("t2_mem_wdata", mem_wdata, 16'hBEEF);
    chk("t2_state", state_dbg, 1);
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(negedge clk);
    chk("t2_rd_mem_we", mem_we, 0);
    chk("t2_rvalid_early", r0_rvalid, 0);
    @(negedge clk);
    chk("t2_rvalid", r0_rvalid, 1);
    chk("t2_rdata", r0_rdata, 16'hBEEF);
    @(negedge clk);
    chk("t2_rvalid_pulse", r0_rvalid, 0);
    chk("t2_rdata_hold", r0_rdata, 16'hBEEF);

    // Aux-only burst read of the top four words
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      r1_req  = (k < 4);
      r1_we   = 1'b0;
      r1_addr = 10'h3FC + 10'(k < 4 ? k : 0);
      @(negedge clk);
      if (k < 4) chk("t4_r1_gnt", r1_gnt, 1);
      if (k == 1) chk("t4_state", state_dbg, 2);
      if (k >= 2 && k < 6) begin
        chk("t4_rvalid", r1_rvalid, 1);
        chk("t4_rdata", r1_rdata, 16'hA3FC + 16'(k - 2));
      end
      if (k == 6) chk("t4_rvalid_end", r1_rvalid, 0);
    end

    // Reset while a core read is in its memory cycle
    @(posedge clk); #1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h3FF;
    @(negedge clk);
    chk("t1_gnt", r0_gnt, 1);
    @(posedge clk); #1;
    r0_req = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("t1_rst_rvalid", r0_rvalid, 0);
    chk("t1_rst_mem_addr", mem_addr, 0);
    chk("t1_rst_conflict", conflict_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_post_rvalid", r0_rvalid, 0);
      chk("t1_post_mem_we", mem_we, 0);
    end

    // Continuous contention: 8 core grants then one aux grant
    idle_cycle();
    run_both(27, 1'b1);

    // Aux drops its request after 7 core grants; hold restarts from zero
    idle_cycle();
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'(k);
      r1_req = (k != 7); r1_we = 1'b0; r1_addr = 10'h100;
      @(negedge clk);
      chk("t5_r0_gnt", r0_gnt, k != 16);
      chk("t5_r1_gnt", r1_gnt, k == 16);
    end

    // Drive the conflict counter into saturation and past it
    idle_cycle();
    run_both(65545, 1'b0);
    chk("t6_sat", conflict_cnt, 16'hFFFF);
    @(negedge clk);
    chk("t6_sat_hold", conflict_cnt, 16'hFFFF);

    repeat (4) idle_cycle();
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
